// File: rtl/gemm_top_core.sv
// gemm_top_core: fixed-latency, fully parallel integer GEMM engine.
// Computes result = alpha*(A x B) + beta*C on whole matrices every clock.
// Three register stages: operand capture, dot products, scale-and-add.
// All arithmetic keeps the low DATA_WIDTH bits. Two's-complement wrap is
// bit-identical to unsigned wrap, so no sign extension is needed.
module gemm_top_core #(
    parameter int DATA_WIDTH    = 32,
    parameter int MATRIX_WIDTH  = 4,
    parameter int MATRIX_HEIGHT = 4,
    parameter int MATRIX_ADJUST = 4
) (
    input  logic                  iclk,
    input  logic                  irst,
    input  logic [DATA_WIDTH-1:0] alpha,
    input  logic [DATA_WIDTH-1:0] beta,
    input  logic [DATA_WIDTH-1:0] a_matrix      [MATRIX_HEIGHT][MATRIX_ADJUST],
    input  logic [DATA_WIDTH-1:0] b_matrix      [MATRIX_ADJUST][MATRIX_WIDTH],
    input  logic [DATA_WIDTH-1:0] c_matrix      [MATRIX_HEIGHT][MATRIX_WIDTH],
    output logic [DATA_WIDTH-1:0] result_matrix [MATRIX_HEIGHT][MATRIX_WIDTH]
);

    localparam logic [DATA_WIDTH-1:0] ZERO_W = {DATA_WIDTH{1'b0}};

    // Stage 1 registers: raw operands
    logic [DATA_WIDTH-1:0] alpha1_r;
    logic [DATA_WIDTH-1:0] beta1_r;
    logic [DATA_WIDTH-1:0] a1_r [MATRIX_HEIGHT][MATRIX_ADJUST];
    logic [DATA_WIDTH-1:0] b1_r [MATRIX_ADJUST][MATRIX_WIDTH];
    logic [DATA_WIDTH-1:0] c1_r [MATRIX_HEIGHT][MATRIX_WIDTH];

    // Stage 2 registers: dot products with alpha/beta/C kept aligned
    logic [DATA_WIDTH-1:0] alpha2_r;
    logic [DATA_WIDTH-1:0] beta2_r;
    logic [DATA_WIDTH-1:0] p2_r [MATRIX_HEIGHT][MATRIX_WIDTH];
    logic [DATA_WIDTH-1:0] c2_r [MATRIX_HEIGHT][MATRIX_WIDTH];

    // Combinational stage results
    logic [DATA_WIDTH-1:0] p_sum_s [MATRIX_HEIGHT][MATRIX_WIDTH];
    logic [DATA_WIDTH-1:0] res_s   [MATRIX_HEIGHT][MATRIX_WIDTH];

    // Stage 1: capture operands, cleared by reset
    always_ff @(posedge iclk) begin
        if (!irst) begin
            alpha1_r <= ZERO_W;
            beta1_r  <= ZERO_W;
            for (int i = 0; i < MATRIX_HEIGHT; i++) begin
                for (int k = 0; k < MATRIX_ADJUST; k++) begin
                    a1_r[i][k] <= ZERO_W;
                end
                for (int j = 0; j < MATRIX_WIDTH; j++) begin
                    c1_r[i][j] <= ZERO_W;
                end
            end
            for (int k = 0; k < MATRIX_ADJUST; k++) begin
                for (int j = 0; j < MATRIX_WIDTH; j++) begin
                    b1_r[k][j] <= ZERO_W;
                end
            end
        end else begin
            alpha1_r <= alpha;
            beta1_r  <= beta;
            a1_r     <= a_matrix;
            b1_r     <= b_matrix;
            c1_r     <= c_matrix;
        end
    end

    // Dot product of each A row with each B column (wrapping sum)
    always_comb begin
        for (int i = 0; i < MATRIX_HEIGHT; i++) begin
            for (int j = 0; j < MATRIX_WIDTH; j++) begin
                p_sum_s[i][j] = ZERO_W;
                for (int k = 0; k < MATRIX_ADJUST; k++) begin
                    p_sum_s[i][j] = p_sum_s[i][j] + a1_r[i][k] * b1_r[k][j];
                end
            end
        end
    end

    // Stage 2: register products plus aligned alpha, beta and C
    always_ff @(posedge iclk) begin
        if (!irst) begin
            alpha2_r <= ZERO_W;
            beta2_r  <= ZERO_W;
            for (int i = 0; i < MATRIX_HEIGHT; i++) begin
                for (int j = 0; j < MATRIX_WIDTH; j++) begin
                    p2_r[i][j] <= ZERO_W;
                    c2_r[i][j] <= ZERO_W;
                end
            end
        end else begin
            alpha2_r <= alpha1_r;
            beta2_r  <= beta1_r;
            p2_r     <= p_sum_s;
            c2_r     <= c1_r;
        end
    end

    // Scale-and-add of stage 2 data
    always_comb begin
        for (int i = 0; i < MATRIX_HEIGHT; i++) begin
            for (int j = 0; j < MATRIX_WIDTH; j++) begin
                res_s[i][j] = alpha2_r * p2_r[i][j] + beta2_r * c2_r[i][j];
            end
        end
    end

    // Stage 3: registered result output
    always_ff @(posedge iclk) begin
        if (!irst) begin
            for (int i = 0; i < MATRIX_HEIGHT; i++) begin
                for (int j = 0; j < MATRIX_WIDTH; j++) begin
                    result_matrix[i][j] <= ZERO_W;
                end
            end
        end else begin
            result_matrix <= res_s;
        end
    end

endmodule

// File: tb/tb_gemm_top_core.sv
// Testbench for gemm_top_core: directed vectors, a reference GEMM model
// checked every cycle, and literal expectations at key points.
module tb_gemm_top_core;

    localparam int DW = 32;
    localparam int N  = 4;
    localparam int M  = 4;
    localparam int K  = 4;

    typedef logic [DW-1:0] mat_mk_t [M][K];
    typedef logic [DW-1:0] mat_kn_t [K][N];
    typedef logic [DW-1:0] mat_mn_t [M][N];

    logic          iclk;
    logic          irst;
    logic [DW-1:0] alpha;
    logic [DW-1:0] beta;
    mat_mk_t       a_m;
    mat_kn_t       b_m;
    mat_mn_t       c_m;
    mat_mn_t       res_m;

    int tests_run;
    int tests_failed;

    gemm_top_core #(
        .DATA_WIDTH   (DW),
        .MATRIX_WIDTH (N),
        .MATRIX_HEIGHT(M),
        .MATRIX_ADJUST(K)
    ) dut (
        .iclk         (iclk),
        .irst         (irst),
        .alpha        (alpha),
        .beta         (beta),
        .a_matrix     (a_m),
        .b_matrix     (b_m),
        .c_matrix     (c_m),
        .result_matrix(res_m)
    );

    initial iclk = 1'b0;
    always #5 iclk = ~iclk;

    // Reference: alpha*(A x B) + beta*C, signed, low 32 bits kept
    function automatic mat_mn_t gemm_ref(input logic [DW-1:0] al, input logic [DW-1:0] be,
                                         input mat_mk_t a, input mat_kn_t b, input mat_mn_t c);
        mat_mn_t r;
        longint  acc;
        longint  tot;
        logic [DW-1:0] p;
        for (int i = 0; i < M; i++) begin
            for (int j = 0; j < N; j++) begin
                acc = 0;
                for (int k = 0; k < K; k++) begin
                    acc = acc + longint'($signed(a[i][k])) * longint'($signed(b[k][j]));
                end
                p   = acc[DW-1:0];
                tot = longint'($signed(al)) * longint'($signed(p))
                    + longint'($signed(be)) * longint'($signed(c[i][j]));
                r[i][j] = tot[DW-1:0];
            end
        end
        return r;
    endfunction

    // Model state: what each past edge fed in, and whether it was a reset
    mat_mn_t zero_m;
    mat_mn_t g_h1;
    mat_mn_t g_h2;
    mat_mn_t g_cur;
    mat_mn_t exp_m;
    logic    rst_prev;
    logic    started;

    initial begin
        for (int i = 0; i < M; i++)
            for (int j = 0; j < N; j++) begin
                zero_m[i][j] = '0;
                g_h1[i][j]   = '0;
                g_h2[i][j]   = '0;
                exp_m[i][j]  = '0;
            end
        rst_prev = 1'b0;
        started  = 1'b0;
    end

    // Expected output after this edge: zero if reset hit now or last edge,
    // otherwise the GEMM of the operands offered two edges ago
    always @(posedge iclk) begin
        g_cur = irst ? gemm_ref(alpha, beta, a_m, b_m, c_m) : zero_m;
        if (!irst || !rst_prev) exp_m = zero_m;
        else                    exp_m = g_h2;
        g_h2     = g_h1;
        g_h1     = g_cur;
        rst_prev = irst;
        if (!irst) started = 1'b1;
    end

    // Compare DUT against the model every cycle once reset has been seen
    always @(negedge iclk) begin
        logic bad;
        if (started) begin
            bad = 1'b0;
            for (int i = 0; i < M; i++)
                for (int j = 0; j < N; j++)
                    if (!bad && res_m[i][j] !== exp_m[i][j]) begin
                        bad = 1'b1;
                        $display("FAIL model_cmp t=%0t [%0d][%0d] got %h expected %h",
                                 $time, i, j, res_m[i][j], exp_m[i][j]);
                    end
            tests_run++;
            if (bad) tests_failed++;
        end
    end

    task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] want);
        tests_run++;
        if (got !== want) begin
            tests_failed++;
            $display("FAIL %s t=%0t got %h expected %h", name, $time, got, want);
        end
    endtask

    task automatic set_identity_a();
        for (int i = 0; i < M; i++)
            for (int k = 0; k < K; k++)
                a_m[i][k] = (i == k) ? 32'd1 : 32'd0;
    endtask

    task automatic fill_all(input logic [DW-1:0] av, input logic [DW-1:0] bv, input logic [DW-1:0] cv);
        for (int i = 0; i < M; i++)
            for (int k = 0; k < K; k++) a_m[i][k] = av;
        for (int k = 0; k < K; k++)
            for (int j = 0; j < N; j++) b_m[k][j] = bv;
        for (int i = 0; i < M; i++)
            for (int j = 0; j < N; j++) c_m[i][j] = cv;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;

        // Reset held for 3 edges with nonzero operands
        irst  = 1'b0;
        alpha = 32'd7;
        beta  = 32'd9;
        fill_all(32'd3, 32'd4, 32'd5);
        repeat (3) @(negedge iclk);
        chk("reset_r00", res_m[0][0], 32'd0);
        chk("reset_r33", res_m[3][3], 32'd0);

        // Release with identity test operands
        irst  = 1'b1;
        alpha = 32'd1;
        beta  = 32'd1;
        fill_all(32'd0, 32'd0, 32'd2);
        set_identity_a();
        for (int k = 0; k < K; k++)
            for (int j = 0; j < N; j++) b_m[k][j] = 32'(4 * k + j + 1);
        @(negedge iclk);
        chk("release_wait1", res_m[3][3], 32'd0);
        @(negedge iclk);
        chk("release_wait2", res_m[3][3], 32'd0);
        @(negedge iclk);
        chk("identity_r33", res_m[3][3], 32'd18);
        chk("identity_r00", res_m[0][0], 32'd3);
        chk("identity_r12", res_m[1][2], 32'd9);

        // Scaling: 3*4 + 2*5
        alpha = 32'd3;
        beta  = 32'd2;
        fill_all(32'd1, 32'd1, 32'd5);
        repeat (3) @(negedge iclk);
        chk("scale_r00", res_m[0][0], 32'd22);
        chk("scale_r23", res_m[2][3], 32'd22);

        // Signed: -2 * 7
        alpha = 32'd1;
        beta  = 32'd0;
        fill_all(32'd0, 32'd0, 32'd0);
        a_m[0][0] = 32'hFFFF_FFFE;
        b_m[0][0] = 32'd7;
        repeat (3) @(negedge iclk);
        chk("signed_r00", res_m[0][0], 32'hFFFF_FFF2);
        chk("signed_r11", res_m[1][1], 32'd0);

        // Wrap: 0x80000000 * 2 drops out of 32 bits
        a_m[0][0] = 32'h8000_0000;
        b_m[0][0] = 32'd2;
        repeat (3) @(negedge iclk);
        chk("wrap_r00", res_m[0][0], 32'd0);

        // Streaming alpha 1,2,3 with A=I, B=1, C=0
        fill_all(32'd0, 32'd1, 32'd0);
        set_identity_a();
        beta  = 32'd1;
        alpha = 32'd1;
        @(negedge iclk);
        alpha = 32'd2;
        @(negedge iclk);
        alpha = 32'd3;
        @(negedge iclk);
        chk("stream_1", res_m[1][3], 32'd1);
        @(negedge iclk);
        chk("stream_2", res_m[1][3], 32'd2);
        @(negedge iclk);
        chk("stream_3", res_m[1][3], 32'd3);

        // Mid-stream reset discards in-flight operands
        alpha = 32'd5;
        @(negedge iclk);
        alpha = 32'd6;
        @(negedge iclk);
        irst  = 1'b0;
        alpha = 32'd7;
        @(negedge iclk);
        chk("midrst_edge", res_m[2][0], 32'd0);
        irst  = 1'b1;
        alpha = 32'd9;
        @(negedge iclk);
        chk("midrst_after1", res_m[2][0], 32'd0);
        @(negedge iclk);
        chk("midrst_after2", res_m[2][0], 32'd0);
        @(negedge iclk);
        chk("midrst_new", res_m[2][0], 32'd9);

        // Held operands keep the result steady
        repeat (3) @(negedge iclk);
        chk("hold_r00", res_m[0][0], 32'd9);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/gemm_top_core.md
Name: gemm_top_core

Overview:
- Fixed-latency, fully parallel integer GEMM engine: result = alpha·(A×B) + beta·C.
- Inputs and outputs are whole matrices on unpacked 2-D array ports.
- Sits between the matrix-load logic and the result consumer in the GEMM power-analysis design.
- No handshake: free-running; new operands are accepted every clock and a result is produced every clock after the pipeline fills.

Parameters:
- DATA_WIDTH, 32: bit width of every matrix element, alpha and beta.
- MATRIX_WIDTH, 4: columns of B, C and result (N).
- MATRIX_HEIGHT, 4: rows of A, C and result (M).
- MATRIX_ADJUST, 4: inner dimension K (columns of A, rows of B).

Ports:
- iclk, input, 1: clock; all state changes on the rising edge.
- irst, input, 1: reset. One clock; reset is synchronous and active-low: irst=0 sampled at a rising iclk edge resets the block.
- alpha, input, DATA_WIDTH: scale factor for A×B.
- beta, input, DATA_WIDTH: scale factor for C.
- a_matrix, input, [MATRIX_HEIGHT][MATRIX_ADJUST] x DATA_WIDTH: operand A.
- b_matrix, input, [MATRIX_ADJUST][MATRIX_WIDTH] x DATA_WIDTH: operand B.
- c_matrix, input, [MATRIX_HEIGHT][MATRIX_WIDTH] x DATA_WIDTH: addend C.
- result_matrix, output, [MATRIX_HEIGHT][MATRIX_WIDTH] x DATA_WIDTH: registered result.

Behaviour:
- Arithmetic:
  - All values are two's-complement signed integers.
  - Every product and sum wraps modulo 2^DATA_WIDTH (keep the low DATA_WIDTH bits); no saturation, no overflow flag.
- Pipeline: 3 register stages, all updating on rising iclk.
  - S1: registers alpha, beta, a_matrix, b_matrix, c_matrix.
  - S2: for each (i,j), registers P[i][j] = Σ_{k=0..K-1} A[i][k]·B[k][j] from S1 data. Also registers alpha, beta and C[i][j] from S1, so they stay aligned with P.
  - S3: result_matrix[i][j] <= alpha·P[i][j] + beta·C[i][j], using S2 data.
- Latency: operands present at rising edge n appear on result_matrix after rising edge n+2. That is 3 edges, counting the capture edge as edge n.
- Throughput: one full matrix result per cycle. Changing operands every cycle yields a matching result stream, each result delayed by the fixed latency.
- Held operands: result_matrix holds the same value indefinitely.
- Reset (irst=0 at an edge):
  - All S1/S2 registers and every result_matrix element become 0 on that edge.
  - Reset has priority over data capture.
  - Reset mid-stream discards all in-flight operands.
- After release (first edge with irst=1): S1 captures; the first valid result appears 2 edges later. Until then result_matrix reads 0.
- Zero operands: alpha=0 gives beta·C; beta=0 gives alpha·A×B.
- No combinational path from any input to result_matrix.
- Parameters need not be equal (rectangular GEMM supported). All dimensions must be ≥1.

Test Plan:
- Reset: hold irst=0 for 3 edges with nonzero inputs -> every result_matrix element reads 0. After release, results stay 0 until the 3rd edge after release.
- Identity check: A=I, B[i][j]=4i+j+1, C=all 2, alpha=1, beta=1 -> result[i][j]=4i+j+3 (e.g. result[3][3]=18), 3 edges after capture.
- Scaling: A=all 1, B=all 1, C=all 5, alpha=3, beta=2 -> each element = 3·4 + 2·5 = 22.
- Signed/wrap: A[0][0]=-2, B[0][0]=7, other A/B elements 0, C=0, alpha=1, beta=0 -> result[0][0]=0xFFFFFFF2 (-14). Separately, A[0][0]=0x80000000, B[0][0]=2, alpha=1 -> result[0][0]=0.
- Streaming: change alpha 1,2,3 on consecutive cycles with A=I, B=all 1, C=0 -> result elements read 1,2,3 on consecutive cycles after latency.
- Mid-stream reset: assert irst=0 for one edge while results are in flight -> result goes to 0 that edge. Pre-reset operands never appear; new operands appear 3 edges after release.
